multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Consumes the opcode/funct3 fields produced by the instruction field decoder and sequences fetch, decode, execute, memory and writeback over one shared memory port.
- Drives every datapath enable and mux select: PC, IR, ALU operands, immediate format, register file write, writeback source.
- Traps and halts on unsupported encodings.

---
 rtl/multicycle_control.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch, decode, execute, memory and writeback over one memory port.
module multicycle_control #(
    parameter int RESET_STATE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] imm_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       instret,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_OP     = 4'd0,
        C_OPIMM  = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_LUI    = 4'd4,
        C_AUIPC  = 4'd5,
        C_BRANCH = 4'd6,
        C_JAL    = 4'd7,
        C_JALR   = 4'd8,
        C_NONE   = 4'd9
    } class_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] RST_LAST = 4'(RESET_STATE_CYCLES - 1);

    state_t     cur_state;
    state_t     next_state;
    class_t     cls;
    class_t     cls_dec;
    logic [3:0] rst_cnt;

    logic [1:0] alu_a;
    logic       alu_b;
    logic [2:0] imm;

    // Live decode; only sampled into cls while in DECODE.
    always_comb begin
        cls_dec = C_NONE;
        case (opcode)
            OPC_OP:     cls_dec = C_OP;
            OPC_OPIMM:  cls_dec = C_OPIMM;
            OPC_LOAD:   cls_dec = C_LOAD;
            OPC_STORE:  cls_dec = C_STORE;
            OPC_LUI:    cls_dec = C_LUI;
            OPC_AUIPC:  cls_dec = C_AUIPC;
            OPC_BRANCH: cls_dec = C_BRANCH;
            OPC_JAL:    cls_dec = C_JAL;
            OPC_JALR:   cls_dec = (funct3 == 3'b000) ? C_JALR : C_NONE;
            default:    cls_dec = C_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_RESET;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= 4'd0;
        end else if (cur_state == S_RESET && rst_cnt != RST_LAST) begin
            rst_cnt <= rst_cnt + 4'd1;
        end else begin
            rst_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls <= C_NONE;
        end else if (cur_state == S_DECODE) begin
            cls <= cls_dec;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_RESET: begin
                if (rst_cnt == RST_LAST) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                next_state = (cls_dec == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_BRANCH:        next_state = S_FETCH;
                    default:         next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    next_state = (cls == C_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB:    next_state = S_FETCH;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_RESET;
        endcase
    end

    // ALU operand selects per class, shared by EXEC and MEM.
    always_comb begin
        alu_a = 2'd0;
        alu_b = 1'b1;
        imm   = IMM_I;
        case (cls)
            C_OP:     alu_b = 1'b0;
            C_STORE:  imm = IMM_S;
            C_LUI: begin
                alu_a = 2'd2;
                imm   = IMM_U;
            end
            C_AUIPC: begin
                alu_a = 2'd1;
                imm   = IMM_U;
            end
            C_BRANCH: begin
                alu_a = 2'd1;
                imm   = IMM_B;
            end
            C_JAL: begin
                alu_a = 2'd1;
                imm   = IMM_J;
            end
            default: begin
                alu_a = 2'd0;
                alu_b = 1'b1;
                imm   = IMM_I;
            end
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        imm_sel      = 3'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        instret      = 1'b0;
        illegal      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_EXEC: begin
                alu_a_sel = alu_a;
                alu_b_sel = alu_b;
                imm_sel   = imm;
                case (cls)
                    C_BRANCH: begin
                        pc_sel  = 2'd1;
                        pc_we   = branch_cond;
                        instret = 1'b1;
                    end
                    C_JAL: begin
                        pc_sel = 2'd1;
                        pc_we  = 1'b1;
                    end
                    C_JALR: begin
                        pc_sel = 2'd2;
                        pc_we  = 1'b1;
                    end
                    default: pc_sel = 2'd0;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == C_STORE);
                alu_a_sel    = alu_a;
                alu_b_sel    = alu_b;
                imm_sel      = imm;
                instret      = mem_ready && (cls == C_STORE);
            end
            S_WB: begin
                rf_we   = 1'b1;
                instret = 1'b1;
                case (cls)
                    C_LOAD:         wb_sel = 2'd1;
                    C_JAL, C_JALR:  wb_sel = 2'd2;
                    default:        wb_sel = 2'd0;
                endcase
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed plus random instruction streams
// checked cycle by cycle against a per-instruction schedule model.
module tb_multicycle_control;

    localparam int RSC = 3;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_cond;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] imm_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       instret;
    logic       illegal;
    logic [2:0] state;

    int checks;
    int failures;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsel;
        logic [1:0] a;
        logic       b;
        logic [2:0] imm;
        logic       rfwe;
        logic [1:0] wb;
        logic       ret;
        logic       ill;
    } exp_t;

    // kind: 0 = writes back, 1 = branch, 2 = load, 3 = store
    typedef struct packed {
        logic       legal;
        logic [1:0] kind;
        logic [1:0] a;
        logic       b;
        logic [2:0] imm;
        logic [1:0] pcsel;
        logic [1:0] wb;
    } attr_t;

    exp_t obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                  pc_sel, alu_a_sel, alu_b_sel, imm_sel, rf_we, wb_sel,
                  instret, illegal};

    multicycle_control #(.RESET_STATE_CYCLES(RSC)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_cond  (branch_cond),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .imm_sel      (imm_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .instret      (instret),
        .illegal      (illegal),
        .state        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic attr_t info(input logic [6:0] op, input logic [2:0] f3);
        attr_t r;
        r = '0;
        r.legal = 1'b1;
        r.b = 1'b1;
        case (op)
            7'b0110011: r.b = 1'b0;
            7'b0010011: r.imm = 3'd0;
            7'b0000011: begin r.kind = 2'd2; r.wb = 2'd1; end
            7'b0100011: begin r.kind = 2'd3; r.imm = 3'd1; end
            7'b0110111: begin r.a = 2'd2; r.imm = 3'd3; end
            7'b0010111: begin r.a = 2'd1; r.imm = 3'd3; end
            7'b1100011: begin
                r.kind = 2'd1; r.a = 2'd1; r.imm = 3'd2; r.pcsel = 2'd1;
            end
            7'b1101111: begin
                r.a = 2'd1; r.imm = 3'd4; r.pcsel = 2'd1; r.wb = 2'd2;
            end
            7'b1100111: begin
                r.pcsel = 2'd2; r.wb = 2'd2;
                r.legal = (f3 == 3'b000);
            end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    task automatic step(input exp_t e, input string tag);
        @(negedge clk);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq(input string tag);
        exp_t e;
        e = '0;
        rst = 1'b1;
        #1;
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s_async observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < RSC; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            step(e, {tag, "_reset_hold"});
        end
    endtask

    task automatic fetch(input int fw, input string tag);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            e = '0; e.st = 3'd1; e.req = 1'b1;
            step(e, {tag, "_fetch_wait"});
        end
        mem_ready = 1'b1;
        e = '0; e.st = 3'd1; e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
        step(e, {tag, "_fetch"});
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int fw, input int mw, input logic bc,
                             input string tag);
        attr_t at;
        exp_t  e;
        at = info(op, f3);
        opcode = op;
        funct3 = f3;
        branch_cond = bc;
        fetch(fw, tag);
        mem_ready = 1'($urandom_range(0, 1));
        e = '0; e.st = 3'd2;
        step(e, {tag, "_decode"});
        if (!at.legal) begin
            for (int i = 0; i < 12; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                opcode = 7'($urandom);
                e = '0; e.st = 3'd6; e.ill = 1'b1;
                step(e, {tag, "_trap"});
            end
            reset_seq(tag);
            return;
        end
        mem_ready = 1'($urandom_range(0, 1));
        e = '0; e.st = 3'd3;
        e.a = at.a; e.b = at.b; e.imm = at.imm; e.pcsel = at.pcsel;
        e.pcwe = (at.kind == 2'd1) ? bc : (at.pcsel != 2'd0);
        e.ret = (at.kind == 2'd1);
        step(e, {tag, "_exec"});
        // Live fields are garbage from here; the class must be held inside.
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
        branch_cond = 1'($urandom_range(0, 1));
        if (at.kind == 2'd1) return;
        if (at.kind >= 2'd2) begin
            for (int i = 0; i <= mw; i++) begin
                mem_ready = (i == mw);
                e = '0; e.st = 3'd4; e.req = 1'b1; e.asel = 1'b1;
                e.we = (at.kind == 2'd3);
                e.a = at.a; e.b = at.b; e.imm = at.imm;
                e.ret = (i == mw) && (at.kind == 2'd3);
                step(e, {tag, "_mem"});
            end
            if (at.kind == 2'd3) return;
        end
        mem_ready = 1'($urandom_range(0, 1));
        e = '0; e.st = 3'd5; e.rfwe = 1'b1; e.ret = 1'b1; e.wb = at.wb;
        step(e, {tag, "_wb"});
    endtask

    logic [6:0] legal_ops [9];

    initial begin
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        checks = 0;
        failures = 0;
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111,
                      7'b1100111};
        rst = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        branch_cond = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        e = '0;
        @(negedge clk);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL reset_state observed=%h expected=%h", obs, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < RSC; i++) step(e, "boot_reset_hold");

        run_instr(7'b0110011, 3'd0, 0, 0, 1'b0, "op");
        run_instr(7'b0000011, 3'd2, 0, 3, 1'b0, "load_wait3");
        run_instr(7'b1100011, 3'd0, 0, 0, 1'b1, "branch_taken");
        run_instr(7'b1100011, 3'd1, 0, 0, 1'b0, "branch_not_taken");
        run_instr(7'b1100111, 3'd0, 0, 0, 1'b0, "jalr");
        run_instr(7'b1101111, 3'd5, 2, 0, 1'b0, "jal_fetch_wait");
        run_instr(7'b0100011, 3'd2, 0, 1, 1'b0, "store");
        run_instr(7'b0110111, 3'd0, 0, 0, 1'b0, "lui");
        run_instr(7'b0010111, 3'd0, 0, 0, 1'b0, "auipc");
        run_instr(7'b0010011, 3'd0, 0, 0, 1'b0, "opimm");
        run_instr(7'b1100111, 3'd1, 0, 0, 1'b0, "jalr_bad_funct3");
        run_instr(7'b1111111, 3'd0, 1, 0, 1'b0, "bad_opcode");

        // Reset while a load is stalled in MEM with mem_req high.
        opcode = 7'b0000011;
        funct3 = 3'd2;
        fetch(0, "mid_mem");
        e = '0; e.st = 3'd2;
        step(e, "mid_mem_decode");
        e = '0; e.st = 3'd3; e.b = 1'b1;
        step(e, "mid_mem_exec");
        mem_ready = 1'b0;
        e = '0; e.st = 3'd4; e.req = 1'b1; e.asel = 1'b1; e.b = 1'b1;
        @(negedge clk);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL mid_mem_pre observed=%h expected=%h", obs, e);
        end
        #2;
        reset_seq("mid_mem");
        run_instr(7'b0110011, 3'd0, 0, 0, 1'b0, "after_mid_mem");

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                op = 7'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            f3 = 3'($urandom);
            if (op == 7'b1100111 && $urandom_range(0, 3) != 0) f3 = 3'd0;
            run_instr(op, f3, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), "rand");
        end

        mem_ready = 1'b0;
        e = '0; e.st = 3'd1; e.req = 1'b1;
        step(e, "final_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
